digital_clock_ctrl: RTL and testbench

Timekeeping and set-mode controller for the digital clock. It consumes the 1 Hz square wave from the one-second pulse generator and advances an hours/minutes/seconds count. A three-state mode FSM, driven by two push buttons, lets the user set hours and minutes. It also resets the pulse generator when set mode exits, so the first second after setting is a full second.

---
 rtl/digital_clock_ctrl.sv | 110 +++++++++++
 tb/tb_digital_clock_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_ctrl.sv
// Timekeeping and set-mode controller: counts hh:mm:ss from a 1 Hz square wave
// and lets the user set hours and minutes with two buttons.
module digital_clock_ctrl #(
  parameter int unsigned RST_HOURS   = 0,
  parameter int unsigned RST_MINUTES = 0
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       sec_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       tick_rst,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       day_pulse
);

  // Out-of-range reset values fall back to zero so counters stay in range.
  localparam logic [4:0] RST_H = 5'((RST_HOURS   <= 23) ? RST_HOURS   : 0);
  localparam logic [5:0] RST_M = 6'((RST_MINUTES <= 59) ? RST_MINUTES : 0);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    UNUSED  = 2'd3
  } state_t;

  state_t state;

  logic sec_q, mode_q, inc_q;
  logic sec_rise, mode_rise, inc_rise;
  logic exit_pend;

  logic       sec_wrap, min_wrap, hr_wrap, day_roll;
  logic [5:0] sec_next, min_next;
  logic [4:0] hr_next;

  // History registers reset high so a level held through reset is not an edge.
  assign sec_rise  = sec_in   & ~sec_q;
  assign mode_rise = btn_mode & ~mode_q;
  assign inc_rise  = btn_inc  & ~inc_q;

  assign mode = state;

  always_comb begin
    sec_wrap = (seconds == 6'd59);
    min_wrap = (minutes == 6'd59);
    hr_wrap  = (hours   == 5'd23);
    sec_next = sec_wrap ? '0 : seconds + 6'd1;
    min_next = min_wrap ? '0 : minutes + 6'd1;
    hr_next  = hr_wrap  ? '0 : hours   + 5'd1;
    day_roll = sec_wrap & min_wrap & hr_wrap;
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state     <= RUN;
      hours     <= RST_H;
      minutes   <= RST_M;
      seconds   <= '0;
      tick_rst  <= 1'b0;
      day_pulse <= 1'b0;
      exit_pend <= 1'b0;
      sec_q     <= 1'b1;
      mode_q    <= 1'b1;
      inc_q     <= 1'b1;
    end else begin
      sec_q     <= sec_in;
      mode_q    <= btn_mode;
      inc_q     <= btn_inc;
      day_pulse <= 1'b0;
      exit_pend <= 1'b0;
      // Pulse-generator reset lands one cycle after mode is back at RUN.
      tick_rst  <= exit_pend;

      case (state)
        RUN: begin
          if (mode_rise) begin
            state   <= SET_HR;
            seconds <= '0;
          end else if (sec_rise) begin
            seconds <= sec_next;
            if (sec_wrap) begin
              minutes <= min_next;
              if (min_wrap) hours <= hr_next;
            end
            day_pulse <= day_roll;
          end
        end
        SET_HR: begin
          if (mode_rise)     state <= SET_MIN;
          else if (inc_rise) hours <= hr_next;
        end
        SET_MIN: begin
          if (mode_rise) begin
            state     <= RUN;
            exit_pend <= 1'b1;
          end else if (inc_rise) begin
            minutes <= min_next;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_digital_clock_ctrl.sv
// Bench for digital_clock_ctrl: time-of-day model in plain seconds, checked
// every cycle, plus directed scenarios with literal expectations.
module tb_digital_clock_ctrl;

  localparam int RH = 22;
  localparam int RM = 10;

  logic       clk_100 = 1'b0;
  logic       rst = 1'b1;
  logic       sec_in = 1'b1;
  logic       btn_mode = 1'b1;
  logic       btn_inc = 1'b1;
  logic       tick_rst;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       day_pulse;

  int checks = 0;
  int failures = 0;

  digital_clock_ctrl #(.RST_HOURS(RH), .RST_MINUTES(RM)) dut (
    .clk_100  (clk_100),
    .rst      (rst),
    .sec_in   (sec_in),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .tick_rst (tick_rst),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .mode     (mode),
    .day_pulse(day_pulse)
  );

  always #5 clk_100 = ~clk_100;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: time of day as seconds since midnight, mode as 0..2.
  int m_tod, m_mode;
  bit m_day, m_tick, m_pend, m_valid;
  bit p_sec, p_mode, p_inc;

  always @(posedge clk_100) begin
    bit rs, rm, ri;
    int h, mi;
    if (rst) begin
      m_tod = RH * 3600 + RM * 60;
      m_mode = 0; m_day = 0; m_tick = 0; m_pend = 0;
      p_sec = 1; p_mode = 1; p_inc = 1;
      m_valid = 1;
    end else begin
      rs = sec_in & !p_sec;
      rm = btn_mode & !p_mode;
      ri = btn_inc & !p_inc;
      m_day = 0;
      m_tick = m_pend;
      m_pend = 0;
      if (rm) begin
        if (m_mode == 0) m_tod = m_tod - (m_tod % 60);
        if (m_mode == 2) m_pend = 1;
        m_mode = (m_mode + 1) % 3;
      end else if (m_mode == 0 && rs) begin
        m_tod = (m_tod + 1) % 86400;
        m_day = (m_tod == 0);
      end else if (m_mode == 1 && ri) begin
        h = (m_tod / 3600 + 1) % 24;
        m_tod = h * 3600 + m_tod % 3600;
      end else if (m_mode == 2 && ri) begin
        mi = ((m_tod / 60) % 60 + 1) % 60;
        m_tod = (m_tod / 3600) * 3600 + mi * 60 + m_tod % 60;
      end
      p_sec = sec_in; p_mode = btn_mode; p_inc = btn_inc;
    end
  end

  always @(posedge clk_100) begin
    #1;
    if (m_valid) begin
      chk("hours",     hours,     m_tod / 3600);
      chk("minutes",   minutes,   (m_tod / 60) % 60);
      chk("seconds",   seconds,   m_tod % 60);
      chk("mode",      mode,      m_mode);
      chk("day_pulse", day_pulse, m_day);
      chk("tick_rst",  tick_rst,  m_tick);
    end
  end

  // which: 0 = sec_in, 1 = btn_mode, 2 = btn_inc; called and returns at negedge
  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0: sec_in = 1'b1;
        1: btn_mode = 1'b1;
        default: btn_inc = 1'b1;
      endcase
      @(negedge clk_100);
      sec_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      @(negedge clk_100);
    end
  endtask

  initial begin
    // Reset with all inputs held high, then keep them high after release.
    repeat (5) @(negedge clk_100);
    rst = 1'b0;
    repeat (3) @(negedge clk_100);
    chk("rst_mode", mode, 0);
    chk("rst_hours", hours, 22);
    chk("rst_minutes", minutes, 10);
    chk("rst_seconds", seconds, 0);
    chk("rst_tick", tick_rst, 0);
    sec_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (2) @(negedge clk_100);
    chk("held_high_no_inc", seconds, 0);

    // Hour set 22 -> 3, minute set 10 -> 11 via 61 increments.
    pulse(1, 1);
    chk("enter_set_hr", mode, 1);
    pulse(2, 5);
    chk("set_hours", hours, 3);
    pulse(1, 1);
    pulse(2, 61);
    chk("set_minutes", minutes, 11);
    chk("set_min_no_carry", hours, 3);
    btn_mode = 1'b1;
    @(posedge clk_100); #1;
    chk("exit_mode", mode, 0);
    chk("exit_tick_early", tick_rst, 0);
    chk("exit_seconds", seconds, 0);
    @(posedge clk_100); #1;
    chk("exit_tick", tick_rst, 1);
    @(posedge clk_100); #1;
    chk("exit_tick_once", tick_rst, 0);
    @(negedge clk_100);
    btn_mode = 1'b0;
    @(negedge clk_100);

    // Preload 23:59:58 and roll over midnight.
    pulse(1, 1);
    pulse(2, 20);
    pulse(1, 1);
    pulse(2, 48);
    pulse(1, 1);
    pulse(0, 58);
    chk("preload_sec", seconds, 58);
    pulse(0, 1);
    chk("pre_roll_h", hours, 23);
    chk("pre_roll_m", minutes, 59);
    chk("pre_roll_s", seconds, 59);
    sec_in = 1'b1;
    @(posedge clk_100); #1;
    chk("roll_day_pulse", day_pulse, 1);
    chk("roll_hours", hours, 0);
    chk("roll_minutes", minutes, 0);
    chk("roll_seconds", seconds, 0);
    @(posedge clk_100); #1;
    chk("roll_day_once", day_pulse, 0);
    @(negedge clk_100);
    sec_in = 1'b0;
    @(negedge clk_100);

    // Mode and inc rise together in RUN: mode wins.
    btn_mode = 1'b1; btn_inc = 1'b1;
    @(negedge clk_100);
    chk("coinc_inc_mode", mode, 1);
    chk("coinc_inc_hours", hours, 0);
    btn_mode = 1'b0; btn_inc = 1'b0;
    @(negedge clk_100);
    pulse(1, 2);

    // Sec and mode rise together at 00:00:30.
    pulse(0, 30);
    chk("run_to_30", seconds, 30);
    sec_in = 1'b1; btn_mode = 1'b1;
    @(negedge clk_100);
    chk("coinc_sec_mode", mode, 1);
    chk("coinc_sec_seconds", seconds, 0);
    chk("coinc_sec_minutes", minutes, 0);
    sec_in = 1'b0; btn_mode = 1'b0;
    @(negedge clk_100);

    // Reset in SET_MIN after three increments.
    pulse(1, 1);
    pulse(2, 3);
    chk("pre_rst_minutes", minutes, 3);
    rst = 1'b1;
    @(posedge clk_100); #1;
    chk("midrst_mode", mode, 0);
    chk("midrst_minutes", minutes, 10);
    chk("midrst_hours", hours, 22);
    chk("midrst_tick", tick_rst, 0);
    @(negedge clk_100);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk_100); #1;
      chk("post_rst_tick", tick_rst, 0);
    end
    @(negedge clk_100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
